// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: compares a and b one CHUNK-bit slice per cycle, MSB slice first, with cascade inputs.
// Latency: done pulses in the cycle after edge t+N (start accepted at edge t); with SEQ_COMPARATOR_EARLY_TERM_EN, after edge t+k+1.
// Backpressure: none; start is only sampled while idle (busy=0) and ignored during a comparison.
//
// Ports: clk (rising edge), rst_n (synchronous, active-low), start/a/b/e/l/g (request, operands, cascade),
//        busy (comparison in progress), done (one-cycle result-valid pulse), GT/LT/EQ (result, held until next done).
// Optional build macro: SEQ_COMPARATOR_EARLY_TERM_EN ends the run at the first differing slice.

module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e,
    input  logic             l,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             LT,
    output logic             EQ
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             e_q, e_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic [KW-1:0]    k_q, k_d;
    // dec_q: an earlier slice already decided; dgt_q: that decision was "greater"
    logic             dec_q, dec_d;
    logic             dgt_q, dgt_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             dec_now;
    logic             dgt_now;
    logic             last_slice;
    logic             finish;

    // Select slice k without disturbing the latched operands.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                slice_a = a_q[WIDTH-1-i*CHUNK -: CHUNK];
                slice_b = b_q[WIDTH-1-i*CHUNK -: CHUNK];
            end
        end
    end

    always_comb begin
        slice_gt   = (slice_a > slice_b);
        slice_lt   = (slice_a < slice_b);
        // The first differing slice wins; later slices cannot override it.
        dec_now    = dec_q | slice_gt | slice_lt;
        dgt_now    = dec_q ? dgt_q : slice_gt;
        last_slice = (k_q == KW'(N - 1));
`ifdef SEQ_COMPARATOR_EARLY_TERM_EN
        finish     = last_slice | dec_now;
`else
        finish     = last_slice;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        l_d     = l_q;
        g_d     = g_q;
        k_d     = k_q;
        dec_d   = dec_q;
        dgt_d   = dgt_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    e_d     = e;
                    l_d     = l;
                    g_d     = g;
                    k_d     = '0;
                    dec_d   = 1'b0;
                    dgt_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dec_d = dec_now;
                dgt_d = dgt_now;
                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (dec_now) begin
                        gt_d = dgt_now;
                        lt_d = ~dgt_now;
                        eq_d = 1'b0;
                    end else begin
                        // All slices equal: cascade passes through untouched, even if illegal.
                        gt_d = g_q;
                        lt_d = l_q;
                        eq_d = e_q;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            k_q     <= '0;
            dec_q   <= 1'b0;
            dgt_q   <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            l_q     <= l_d;
            g_q     <= g_d;
            k_q     <= k_d;
            dec_q   <= dec_d;
            dgt_q   <= dgt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign GT   = gt_q;
    assign LT   = lt_q;
    assign EQ   = eq_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16/CHUNK=4 plus a CHUNK=16 instance).
// Latency expectations follow the SEQ_COMPARATOR_EARLY_TERM_EN build setting.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_seq_comparator;

`ifdef SEQ_COMPARATOR_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic [15:0] a;
    logic [15:0] b;
    logic        e, l, g;
    logic        busy, done, gt, lt, eq;
    logic        busy1, done1, gt1, lt1, eq1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_comparator #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .e(e), .l(l), .g(g),
        .busy(busy), .done(done), .GT(gt), .LT(lt), .EQ(eq)
    );

    seq_comparator #(.WIDTH(16), .CHUNK(16)) u_dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .e(e), .l(l), .g(g),
        .busy(busy1), .done(done1), .GT(gt1), .LT(lt1), .EQ(eq1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns at the falling edge just after the accepting edge (sample 0).
    task automatic launch(input logic [15:0] aa, input logic [15:0] bb,
                          input logic ee, input logic ll, input logic gg);
        @(negedge clk);
        a = aa; b = bb; e = ee; l = ll; g = gg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample j0 is the current falling edge; returns at the done sample with its index, or -1.
    task automatic wait_done(input int j0, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int j = j0; j < j0 + 20; j++) begin
            if (done) begin
                lat = j;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    int lat, bcnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        a = '0; b = '0; e = 1'b0; l = 1'b0; g = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, gt, lt, eq}, 5'b0);
        check("reset_outs_n1", {busy1, done1, gt1, lt1, eq1}, 5'b0);
        rst_n = 1'b1;

        // Equal operands, cascade says equal
        launch(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("eq_lat", lat, 4);
        check("eq_busy_cycles", bcnt, 4);
        check("eq_busy_in_done", busy, 0);
        check("eq_res", {gt, lt, eq}, 3'b001);
        @(negedge clk);
        check("eq_done_one_cycle", done, 0);
        check("eq_res_held", {gt, lt, eq}, 3'b001);

        // MSB slice decides greater
        launch(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("msb_gt_lat", lat, ET ? 1 : 4);
        check("msb_gt_res", {gt, lt, eq}, 3'b100);

        // Data decision beats cascade g=1
        launch(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        wait_done(0, lat, bcnt);
        check("lsb_lt_lat", lat, 4);
        check("lsb_lt_res", {gt, lt, eq}, 3'b010);

        // Decided at slice k=2 (A > 3)
        launch(16'h12A4, 16'h1234, 1'b0, 1'b1, 1'b0);
        wait_done(0, lat, bcnt);
        check("mid_gt_lat", lat, ET ? 3 : 4);
        check("mid_gt_res", {gt, lt, eq}, 3'b100);

        // Decided at last slice
        launch(16'h1233, 16'h1234, 1'b1, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("last_lt_lat", lat, 4);
        check("last_lt_res", {gt, lt, eq}, 3'b010);

        // Illegal cascade passes through on equal data
        launch(16'h5555, 16'h5555, 1'b1, 1'b1, 1'b1);
        wait_done(0, lat, bcnt);
        check("casc_all_lat", lat, 4);
        check("casc_all_res", {gt, lt, eq}, 3'b111);

        launch(16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        wait_done(0, lat, bcnt);
        check("casc_lt_res", {gt, lt, eq}, 3'b010);

        // Operand change and start pulse during RUN are ignored
        launch(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrun_busy", busy, 1);
        wait_done(2, lat, bcnt);
        check("midrun_lat", lat, 4);
        check("midrun_res", {gt, lt, eq}, 3'b010);

        // Reset aborts a comparison in progress
        launch(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check("abort_outs", {busy, done, gt, lt, eq}, 5'b0);
        @(negedge clk);
        check("abort_start_ignored", {busy, done}, 2'b0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("abort_no_done", {busy, done}, 2'b0);

        // First compare after reset behaves like power-up
        launch(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("post_rst_lat", lat, 4);
        check("post_rst_busy_cycles", bcnt, 4);
        check("post_rst_res", {gt, lt, eq}, 3'b001);

        // Back-to-back with start asserted in the done cycle
        launch(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("b2b_first_lat", lat, ET ? 1 : 4);
        check("b2b_first_res", {gt, lt, eq}, 3'b100);
        a = 16'h0000; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_bubble", busy, 1);
        check("b2b_gt_held", {gt, lt, eq}, 3'b100);
        wait_done(0, lat, bcnt);
        check("b2b_second_lat", lat, ET ? 1 : 4);
        check("b2b_second_res", {gt, lt, eq}, 3'b010);

        // Single-slice instance (CHUNK = WIDTH)
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; e = 1'b1; l = 1'b0; g = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_busy", {busy1, done1}, 2'b10);
        @(negedge clk);
        check("n1_done", {busy1, done1}, 2'b01);
        check("n1_res", {gt1, lt1, eq1}, 3'b001);
        @(negedge clk);
        check("n1_done_one_cycle", done1, 0);

        a = 16'h0000; b = 16'h0001; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("n1_lt_done", done1, 1);
        check("n1_lt_res", {gt1, lt1, eq1}, 3'b010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
